// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_INCR      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

  function automatic logic misaligned(input logic [31:0] addr);
    return |addr[1:0];
  endfunction

endpackage

// File: rtl/pc_sequencer_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  count <= '0;
    else if (inc && count != '1) count <= count + ONE;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC and decides advance/redirect/stall/halt,
// driving PC write-enable and IF/ID, ID/EX flushes from one place.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Stall,
  input  logic             Jump,
  input  logic [31:0]      JumpTarget,
  input  logic             BranchTaken,
  input  logic [31:0]      BranchTarget,
  input  logic             Halt,
  output logic [31:0]      PC,
  output logic             PCWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             Fault,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] RedirectCount
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fault_q;
  logic        redir_inc;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_d == ST_FAULT) fault_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    PCWrite   = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    redir_inc = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (BranchTaken) begin
          // Flushes still go out on a bad target; only the PC/count update is suppressed.
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
          if (misaligned(BranchTarget)) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = BranchTarget;
            redir_inc = 1'b1;
          end
        end else if (Stall) begin
          PCWrite   = 1'b0;
          IDEXFlush = 1'b1;
        end else if (Jump) begin
          IFIDFlush = 1'b1;
          if (misaligned(JumpTarget)) begin
            state_d = ST_FAULT;
          end else begin
            pc_d      = JumpTarget;
            redir_inc = 1'b1;
          end
        end else if (Halt) begin
          state_d   = ST_HALT;
          IFIDFlush = 1'b1;
        end else begin
          pc_d = pc_q + PC_INCR;
        end
      end
      ST_HALT: begin
        PCWrite   = 1'b0;
        IFIDFlush = 1'b1;
      end
      ST_FAULT: begin
        PCWrite   = 1'b0;
        IFIDFlush = 1'b1;
        IDEXFlush = 1'b1;
      end
      default: begin
        state_d = ST_FAULT;
        PCWrite = 1'b0;
      end
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (Clk),
    .rst_n (Rst),
    .inc   (redir_inc),
    .count (RedirectCount)
  );

  assign PC    = pc_q;
  assign State = state_q;
  assign Fault = fault_q;

endmodule
